// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and round-robin search helper for mux4_rr_arbiter.
package mux4_rr_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

    // First set request in order last+1, last+2, last+3, last; returns last if none set.
    function automatic logic [SEL_W-1:0] rr_next_idx(input logic [NUM_REQ-1:0] req,
                                                     input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] res;
        res = last;
        // Walk from lowest to highest priority so the last hit wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx]) res = idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Producer/consumer bundle for mux4_rr_arbiter; slave is the arbiter side.
interface mux4_rr_arbiter_if
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 3
);
    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   x0;
    logic [WIDTH-1:0]   x1;
    logic [WIDTH-1:0]   x2;
    logic [WIDTH-1:0]   x3;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   y;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output req, x0, x1, x2, x3, out_ready,
        input  gnt, sel, y, out_valid
    );

    modport slave (
        input  req, x0, x1, x2, x3, out_ready,
        output gnt, sel, y, out_valid
    );

endinterface

// File: rtl/mux4_sel.sv
// Combinational WIDTH-bit 4:1 selector.
module mux4_sel
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [SEL_W-1:0] i_sel,
    input  logic [WIDTH-1:0] i_x0,
    input  logic [WIDTH-1:0] i_x1,
    input  logic [WIDTH-1:0] i_x2,
    input  logic [WIDTH-1:0] i_x3,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = i_x0;
        unique case (i_sel)
            2'd0: o_y = i_x0;
            2'd1: o_y = i_x1;
            2'd2: o_y = i_x2;
            2'd3: o_y = i_x3;
            default: o_y = i_x0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four producers; captures the winner's word and holds it
// until the sink accepts, re-arbitrating in the accept cycle for back-to-back transfers.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input logic                clk,
    input logic                rst_n,
    mux4_rr_arbiter_if.slave   io_bus
);

    state_e             r_state;
    logic [SEL_W-1:0]   r_last;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_REQ-1:0] r_gnt;
    logic [WIDTH-1:0]   r_y;
    logic               r_valid;

    logic               w_accept;
    logic [SEL_W-1:0]   w_arb_last;
    logic [SEL_W-1:0]   w_idx;
    logic               w_any;
    logic [WIDTH-1:0]   w_mux_y;

    // On accept the served requester must already count as "last" for this arbitration.
    always_comb begin
        w_accept   = (r_state == StHold) && io_bus.out_ready;
        w_arb_last = w_accept ? r_sel : r_last;
        w_idx      = rr_next_idx(io_bus.req, w_arb_last);
        w_any      = |io_bus.req;
    end

    mux4_sel #(
        .WIDTH (WIDTH)
    ) u_mux4_sel (
        .i_sel (w_idx),
        .i_x0  (io_bus.x0),
        .i_x1  (io_bus.x1),
        .i_x2  (io_bus.x2),
        .i_x3  (io_bus.x3),
        .o_y   (w_mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_last  <= 2'b11;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_sel   <= w_idx;
                        r_gnt   <= NUM_REQ'(1) << w_idx;
                        r_y     <= w_mux_y;
                        r_valid <= 1'b1;
                        r_state <= StHold;
                    end
                end
                StHold: begin
                    if (w_accept) begin
                        r_last <= r_sel;
                        if (w_any) begin
                            r_sel <= w_idx;
                            r_gnt <= NUM_REQ'(1) << w_idx;
                            r_y   <= w_mux_y;
                        end else begin
                            r_gnt   <= '0;
                            r_valid <= 1'b0;
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.gnt       = r_gnt;
    assign io_bus.sel       = r_sel;
    assign io_bus.y         = r_y;
    assign io_bus.out_valid = r_valid;

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one WIDTH-bit 4:1 selection path among four requesters and presents the winner's word to a single downstream sink through a valid/ready handshake. It owns the select code of the 4:1 datapath, captures the granted word into an output register, and holds it until the sink accepts. It sits between four producer ports and one consumer port.

## Interface
- WIDTH, 3, data width of every requester word and of the output word
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  4  per-requester request; req[i] means word xi is valid
- x0, x1, x2, x3  in  WIDTH  requester data words
- gnt  out  4  one-hot grant; gnt[i]=1 while requester i's word is held on y
- sel  out  2  current select code driven to the 4:1 path (binary index of the winner)
- y  out  WIDTH  registered output word
- out_valid  out  1  y holds an unaccepted word
- out_ready  in  1  sink accepts y when out_valid & out_ready

## Operation
- Two states: IDLE (out_valid=0, gnt=0) and HOLD (out_valid=1, gnt one-hot).
- Pointer last[1:0] records the most recently accepted requester; search order is last+1, last+2, last+3, last (mod 4, wraps 3->0).
- IDLE: if any req bit is set, pick the first set bit in search order; register sel=index, gnt=1<<index, y=x[index]; go to HOLD. No req: stay IDLE.
- HOLD: y, sel, gnt are frozen regardless of req or x changes (word already captured).
- HOLD with out_valid & out_ready (accept): last<=sel. Same cycle, re-arbitrate using the updated last: if any req set, load next winner (sel, gnt, y) and stay in HOLD (back-to-back, no bubble); otherwise go to IDLE, gnt<=0, out_valid<=0. The requester just served has lowest priority in this re-arbitration.
- A requester dropping req while granted does not cancel its grant; the word is still delivered.
- Grant is the producer's acknowledge: producer i must treat gnt[i] rising as "word taken" and may change xi/req[i] the next cycle.
- sel, y are only meaningful while out_valid=1; they keep their last value in IDLE.

## Timing
- Reset (async assert, sync release): state=IDLE, gnt=4'b0000, sel=2'b00, y=0, out_valid=0, last=2'b11 (so requester 0 has top priority first).
- Latency: req sampled at edge N -> gnt, sel, y, out_valid valid after edge N (visible in cycle N+1).
- Throughput: one word per cycle while out_ready=1 and requests are present.
- out_ready low: HOLD indefinitely; out_valid never drops without acceptance.
- Reset asserted mid-HOLD: word discarded, outputs return to reset values immediately; no partial state survives.
- All req bits set and out_ready=1 continuously: grant sequence 0,1,2,3,0,... each requester served once per 4 words (starvation-free).
- out_ready is ignored in IDLE.

## Structure
- Shared package: NUM_REQ=4, SEL_W=2, state encoding (IDLE=1'b0, HOLD=1'b1), and the round-robin next-index function.
- One sub-module: mux4_sel (parameterised WIDTH, 2-bit select, four WIDTH inputs, combinational) driven by the arbiter's next-winner index; its output feeds the y register.
- Arbiter FSM, pointer, and output registers live in the top module.

## Test plan
- Reset then req=4'b0101, x0=3'd5, x2=3'd6, out_ready=1 -> cycle 1: gnt=0001, sel=0, y=5, out_valid=1; cycle 2: gnt=0100, sel=2, y=6; then IDLE once req cleared.
- req=4'b1111 held, out_ready=1 for 8 cycles -> sel sequence 0,1,2,3,0,1,2,3, out_valid=1 throughout.
- Grant to requester 1 (x1=3'd3), out_ready=0 for 5 cycles while x1 changes to 3'd7 and req changes -> y stays 3, gnt stays 0010; on out_ready=1 accept then next winner from index 2.
- Single requester req=4'b1000 continuously, out_ready=1 -> gnt=1000 every cycle, back-to-back, no bubble.
- rst_n pulsed low while HOLD with y=3'd4 -> out_valid=0, gnt=0, y=0, sel=0 asynchronously; after release with req=4'b0010 -> gnt=0010 next edge.
- IDLE with req=0, out_ready toggling -> out_valid stays 0, gnt stays 0, last unchanged.
